// File: rtl/line_memory.sv
// line_memory: bottom-level backing store answering READ/RFO/WRITE/NOP line transfers; DEPTH lines of LINEW bits.
// Latency: valid pulses READ_LAT (READ/RFO), WRITE_LAT (WRITE) or 1 (NOP) cycles after the accept edge.
// Backpressure: none; request is level-held by the master, re-accepted only after it drops. MEM_STATS_EN adds rd_count/wr_count.
module line_memory #(
    parameter int ADDRBITS  = 32,
    parameter int LINEW     = 512,
    parameter int DEPTH     = 1024,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                request,
    input  logic [1:0]          operation,
    input  logic [ADDRBITS-1:0] addr,
    input  logic [LINEW-1:0]    d_in,
    output logic [LINEW-1:0]    d_out,
    output logic                d_oe,
    output logic                valid,
    output logic                evict,
    output logic                busy
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
`endif
);

    localparam int OFF    = $clog2(LINEW / 8);
    localparam int IDXW   = $clog2(DEPTH);
    localparam int MAXLAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RFO   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_RELEASE} state_t;

    if (READ_LAT < 1 || WRITE_LAT < 1) begin : g_bad_lat
        $error("line_memory: READ_LAT and WRITE_LAT must be >= 1");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("line_memory: DEPTH must be a power of two");
    end
    if ((LINEW % 8) != 0) begin : g_bad_linew
        $error("line_memory: LINEW must be a multiple of 8");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [LINEW-1:0]  dat_q, dat_d;
    logic [LINEW-1:0]  mem [DEPTH];
    logic [LINEW-1:0]  rd_line_q;
    logic              mem_re;
    logic              mem_we;
    logic              op_is_rd;

    // Only the line-index field of the address selects storage; the rest is ignored.
    logic unused_addr;
    assign unused_addr = ^{addr[ADDRBITS-1:OFF+IDXW], addr[OFF-1:0]};

    assign op_is_rd = (op_q == OP_READ) || (op_q == OP_RFO);

    // Next-state logic: accept in IDLE, count down in BUSY, one RESP cycle, then wait for request low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (request) begin
                    state_d = S_BUSY;
                    op_d    = operation;
                    idx_d   = addr[OFF +: IDXW];
                    dat_d   = d_in;
                    case (operation)
                        OP_READ, OP_RFO: cnt_d = CW'(READ_LAT - 1);
                        OP_WRITE:        cnt_d = CW'(WRITE_LAT - 1);
                        default:         cnt_d = '0;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    // Fetch on the edge into RESP so the line is on d_out during RESP.
                    mem_re  = op_is_rd;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_RELEASE;
                mem_we  = (op_q == OP_WRITE);
            end
            S_RELEASE: begin
                if (!request) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transaction state; reset drops any in-flight request before it can write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            idx_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
        end
    end

    // Line array with registered read port; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx_q] <= dat_q;
        end
        if (mem_re) begin
            rd_line_q <= mem[idx_q];
        end
    end

    assign valid = (state_q == S_RESP);
    assign d_oe  = valid && op_is_rd;
    assign d_out = d_oe ? rd_line_q : '0;
    assign busy  = (state_q != S_IDLE);
    assign evict = 1'b0;

`ifdef MEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    // Saturating completion counters, bumped at the RESP edge.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == S_RESP) begin
            if (op_is_rd && rd_count_q != 32'hFFFF_FFFF) begin
                rd_count_d = rd_count_q + 32'd1;
            end
            if (op_q == OP_WRITE && wr_count_q != 32'hFFFF_FFFF) begin
                wr_count_d = wr_count_q + 32'd1;
            end
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_line_memory.sv
// Bench for line_memory: directed scenarios plus randomized traffic against an associative-array line model.
// Timing reference: inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_line_memory;

    localparam int RL    = 4;
    localparam int WL    = 2;
    localparam int DEPTH = 1024;
    localparam int OFF   = 6;

    localparam logic [1:0] NOP   = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RFO   = 2'd3;

    typedef logic [511:0] line_t;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        request = 1'b0;
    logic [1:0]  operation = 2'd0;
    logic [31:0] addr = 32'd0;
    line_t       d_in = '0;
    line_t       d_out;
    logic        d_oe, valid, evict, busy;
`ifdef MEM_STATS_EN
    logic [31:0] rd_count, wr_count;
`endif

    int tests = 0;
    int fails = 0;
    line_t model [int];

    always #5 clock = ~clock;

    line_memory #(.ADDRBITS(32), .LINEW(512), .DEPTH(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
        .clock(clock), .reset(rst_n), .request(request), .operation(operation), .addr(addr),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .valid(valid), .evict(evict), .busy(busy)
`ifdef MEM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        if (op == READ || op == RFO) return RL;
        if (op == WRITE) return WL;
        return 1;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> OFF) % DEPTH);
    endfunction

    // Drives one transaction; reports latency from the accept edge, the data seen at valid, and whether the following cycle is quiet.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input line_t d,
                           output int lat, output line_t rd, output logic oe, output logic tail_ok, output logic ev);
        @(negedge clock);
        request = 1'b1; operation = op; addr = a; d_in = d;
        @(posedge clock); #1;
        operation = 2'($urandom); addr = $urandom; d_in = rand_line();
        lat = -1; rd = '0; oe = 1'b0; ev = evict;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin @(posedge clock); #1; end
            ev = ev | evict;
            if (valid) begin lat = c; rd = d_out; oe = d_oe; break; end
        end
        @(posedge clock); #1;
        tail_ok = !valid && !d_oe && (d_out == '0);
        @(negedge clock);
        request = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clock); #1;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
        tests++; if (d_oe !== 1'b0) begin fails++; $display("FAIL reset_d_oe: got %b want 0", d_oe); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (evict !== 1'b0) begin fails++; $display("FAIL reset_evict: got %b want 0", evict); end
        tests++; if (d_out !== '0) begin fails++; $display("FAIL reset_d_out: got %h want 0", d_out); end
        @(negedge clock); rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; line_t rd, p; logic oe, tl, ev;
        p = rand_line();
        run_txn(WRITE, 32'h0000_0040, p, lat, rd, oe, tl, ev);
        model[line_of(32'h40)] = p;
        tests++; if (lat !== WL) begin fails++; $display("FAIL wr_lat: got %0d want %0d", lat, WL); end
        tests++; if (oe !== 1'b0) begin fails++; $display("FAIL wr_d_oe: got %b want 0", oe); end
        run_txn(READ, 32'h0000_0040, rand_line(), lat, rd, oe, tl, ev);
        tests++; if (lat !== RL) begin fails++; $display("FAIL rd_lat: got %0d want %0d", lat, RL); end
        tests++; if (rd !== p) begin fails++; $display("FAIL rd_data: got %h want %h", rd, p); end
        tests++; if (oe !== 1'b1) begin fails++; $display("FAIL rd_d_oe: got %b want 1", oe); end
        tests++; if (tl !== 1'b1) begin fails++; $display("FAIL rd_one_cycle: got %b want 1", tl); end
    endtask

    task automatic test_wrap();
        int lat; line_t rd, p; logic oe, tl, ev;
        logic [31:0] a;
        a = 32'((DEPTH - 1) << OFF);
        p = rand_line();
        run_txn(WRITE, a, p, lat, rd, oe, tl, ev);
        model[DEPTH - 1] = p;
        run_txn(READ, a + 32'(DEPTH << OFF), rand_line(), lat, rd, oe, tl, ev);
        tests++; if (rd !== p) begin fails++; $display("FAIL wrap_data: got %h want %h", rd, p); end
        run_txn(READ, (a | 32'h3F) + 32'(5 * (DEPTH << OFF)), rand_line(), lat, rd, oe, tl, ev);
        tests++; if (rd !== p) begin fails++; $display("FAIL wrap_offset_data: got %h want %h", rd, p); end
    endtask

    task automatic test_ops();
        int lat; line_t rd; logic oe, tl, ev;
        run_txn(NOP, 32'h0000_0040, rand_line(), lat, rd, oe, tl, ev);
        tests++; if (lat !== 1) begin fails++; $display("FAIL nop_lat: got %0d want 1", lat); end
        tests++; if (oe !== 1'b0 || rd !== '0) begin fails++; $display("FAIL nop_bus: got oe=%b data=%h want oe=0 data=0", oe, rd); end
        run_txn(READ, 32'h0000_0040, rand_line(), lat, rd, oe, tl, ev);
        tests++; if (rd !== model[1]) begin fails++; $display("FAIL nop_unchanged: got %h want %h", rd, model[1]); end
        run_txn(RFO, 32'h0000_0040, rand_line(), lat, rd, oe, tl, ev);
        tests++; if (lat !== RL) begin fails++; $display("FAIL rfo_lat: got %0d want %0d", lat, RL); end
        tests++; if (rd !== model[1] || oe !== 1'b1) begin fails++; $display("FAIL rfo_data: got oe=%b %h want oe=1 %h", oe, rd, model[1]); end
        tests++; if (ev !== 1'b0 || tl !== 1'b1) begin fails++; $display("FAIL rfo_evict_tail: got evict=%b tail=%b want 0 1", ev, tl); end
    endtask

    task automatic test_held();
        int lat, pulses, busy_low; line_t rd; logic oe, tl, ev;
        @(negedge clock);
        request = 1'b1; operation = READ; addr = 32'h0000_0040; d_in = rand_line();
        lat = -1; pulses = 0; busy_low = 0;
        for (int c = 0; c <= RL + 10; c++) begin
            @(posedge clock); #1;
            if (valid) begin pulses++; if (lat < 0) lat = c; end
            if (!busy) busy_low++;
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL held_pulses: got %0d want 1", pulses); end
        tests++; if (lat !== RL) begin fails++; $display("FAIL held_lat: got %0d want %0d", lat, RL); end
        tests++; if (busy_low !== 0) begin fails++; $display("FAIL held_busy: got %0d idle cycles want 0", busy_low); end
        @(negedge clock); request = 1'b0;
        @(posedge clock); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL held_release_busy: got %b want 0", busy); end
        run_txn(READ, 32'h0000_0040, rand_line(), lat, rd, oe, tl, ev);
        tests++; if (lat !== RL || rd !== model[1]) begin fails++; $display("FAIL held_next_accept: got lat=%0d want %0d", lat, RL); end
    endtask

    task automatic test_reset_midop();
        int lat, pulses, busy_seen; line_t rd, q, pat; logic oe, tl, ev;
        q = rand_line();
        run_txn(WRITE, 32'(3 << OFF), q, lat, rd, oe, tl, ev);
        model[3] = q;
        pat = {64{8'hA5}};
        @(negedge clock);
        request = 1'b1; operation = WRITE; addr = 32'(3 << OFF); d_in = pat;
        @(posedge clock); #1;
        @(negedge clock); rst_n = 1'b0;
        pulses = 0; busy_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            if (valid) pulses++;
            if (busy) busy_seen++;
        end
        @(negedge clock); request = 1'b0; rst_n = 1'b1;
        tests++; if (pulses !== 0) begin fails++; $display("FAIL midrst_valid: got %0d pulses want 0", pulses); end
        tests++; if (busy_seen !== 0) begin fails++; $display("FAIL midrst_busy: got %0d busy cycles want 0", busy_seen); end
        run_txn(READ, 32'(3 << OFF), rand_line(), lat, rd, oe, tl, ev);
        tests++; if (rd !== q) begin fails++; $display("FAIL midrst_data: got %h want %h", rd, q); end
    endtask

    task automatic test_back_to_back();
        int lat; line_t rd, p; logic oe, tl, ev;
        for (int i = 0; i < 3; i++) begin
            p = rand_line();
            run_txn(WRITE, 32'((7 << OFF) + (i << 20)), p, lat, rd, oe, tl, ev);
            model[7] = p;
            run_txn(READ, 32'(7 << OFF), rand_line(), lat, rd, oe, tl, ev);
            tests++; if (rd !== p) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rd, p); end
        end
    endtask

    task automatic test_random();
        int lat, idx; line_t rd, d; logic oe, tl, ev;
        logic [1:0] op; logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 7);
            op  = 2'($urandom_range(0, 3));
            a   = 32'(($urandom_range(0, 15) * DEPTH + idx) << OFF) | 32'($urandom_range(0, 63));
            d   = rand_line();
            run_txn(op, a, d, lat, rd, oe, tl, ev);
            tests++; if (lat !== lat_of(op)) begin fails++; $display("FAIL rnd_lat[%0d]: op=%0d got %0d want %0d", i, op, lat, lat_of(op)); end
            tests++; if (oe !== (op == READ || op == RFO) || tl !== 1'b1 || ev !== 1'b0) begin
                fails++; $display("FAIL rnd_bus[%0d]: op=%0d got oe=%b tail=%b evict=%b", i, op, oe, tl, ev);
            end
            if (op == WRITE) model[idx] = d;
            if ((op == READ || op == RFO) && model.exists(idx)) begin
                tests++; if (rd !== model[idx]) begin fails++; $display("FAIL rnd_data[%0d]: got %h want %h", i, rd, model[idx]); end
            end
        end
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats();
        int lat; line_t rd; logic oe, tl, ev;
        logic [1:0] ops [6];
        ops = '{READ, WRITE, READ, RFO, WRITE, READ};
        @(negedge clock); rst_n = 1'b0;
        @(negedge clock); rst_n = 1'b1;
        tests++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin fails++; $display("FAIL stats_init: got %0d/%0d want 0/0", rd_count, wr_count); end
        foreach (ops[i]) run_txn(ops[i], 32'(i << OFF), rand_line(), lat, rd, oe, tl, ev);
        tests++; if (rd_count !== 32'd4) begin fails++; $display("FAIL stats_rd: got %0d want 4", rd_count); end
        tests++; if (wr_count !== 32'd2) begin fails++; $display("FAIL stats_wr: got %0d want 2", wr_count); end
        @(negedge clock); rst_n = 1'b0;
        #1;
        tests++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin fails++; $display("FAIL stats_reset: got %0d/%0d want 0/0", rd_count, wr_count); end
        @(negedge clock); rst_n = 1'b1;
        model.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_ops();
        test_held();
        test_reset_midop();
        test_back_to_back();
        test_random();
`ifdef MEM_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
